sprite_rom_arbiter: RTL and testbench



---
 rtl/sprite_rom_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite ROM among render requesters.
// Bursts are bounded; a tag pipeline steers each returned word back to the requester that issued it.
module sprite_rom_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned ROM_LAT   = 2,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    frame_start,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        last,
    input  logic [N_REQ*ADDR_W-1:0] addr_in,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rom_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_nxt;
    logic [PTR_W-1:0]    owner;
    logic [PTR_W-1:0]    owner_nxt;
    logic [PTR_W-1:0]    owner_inc;
    logic [PTR_W-1:0]    cand;
    logic [PTR_W-1:0]    sel;
    logic                found;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [N_REQ-1:0]    gnt_nxt;
    logic                beat;
    logic                end_burst;
    logic [ADDR_W-1:0]   addr_hold;
    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    logic [N_REQ-1:0]    tag_pipe [ROM_LAT];
    logic                pipe_busy;

    // Unpack the flat address bus so the owner can index it directly.
    for (genvar i = 0; i < N_REQ; i++) begin : g_addr
        assign addr_arr[i] = addr_in[i*ADDR_W +: ADDR_W];
    end

    assign beat      = rstn && (state == BURST) && req[owner] && !frame_start;
    assign owner_inc = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

    assign rom_en   = beat;
    assign rom_addr = beat ? addr_arr[owner] : addr_hold;
    assign rd_valid = tag_pipe[ROM_LAT-1];
    assign rd_data  = rom_data;
    assign busy     = (state == BURST) || pipe_busy;

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) begin
            pipe_busy = pipe_busy | (|tag_pipe[i]);
        end
    end

    // Rotating priority search starting at ptr.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        end_burst = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (frame_start) begin
                    ptr_nxt = '0;
                end else if (found) begin
                    state_nxt = BURST;
                    owner_nxt = sel;
                    gnt_nxt   = N_REQ'(1) << sel;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (frame_start || !req[owner]) begin
                    end_burst = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (last[owner] || (cnt == CNT_W'(MAX_BURST - 1))) begin
                        end_burst = 1'b1;
                    end
                end
                if (end_burst) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = frame_start ? '0 : owner_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            addr_hold <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            if (beat) begin
                addr_hold <= addr_arr[owner];
            end
        end
    end

    // Return tags travel alongside the ROM latency; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= beat ? gnt : '0;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomised bench for sprite_rom_arbiter against a transaction-level reference model
// with a synchronous-read ROM stand-in.
module tb_sprite_rom_arbiter;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 12;
    localparam int unsigned ROM_LAT   = 2;
    localparam int unsigned MAX_BURST = 8;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    frame_start;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        last;
    logic [N_REQ*ADDR_W-1:0] addr_in;
    logic [N_REQ-1:0]        gnt;
    logic                    rom_en;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;
    logic [N_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]       rd_data;
    logic                    busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state.
    int                m_owner = -1;
    int                m_ptr   = 0;
    int                m_cnt   = 0;
    logic [ADDR_W-1:0] m_hold  = '0;
    int                q_due  [$];
    int                q_who  [$];
    logic [ADDR_W-1:0] q_addr [$];

    logic [ADDR_W-1:0] rom_pipe [ROM_LAT];

    always #5 clk = ~clk;

    sprite_rom_arbiter #(
        .N_REQ     (N_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ROM_LAT   (ROM_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_start (frame_start),
        .req         (req),
        .last        (last),
        .addr_in     (addr_in),
        .gnt         (gnt),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [31:0] h;
        h = 32'(a) * 32'd2654435761;
        return DATA_W'(h >> 13) ^ DATA_W'(a);
    endfunction

    // ROM stand-in: address registered through ROM_LAT stages.
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_word(rom_pipe[ROM_LAT-1]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs mid-cycle, then advance the model across the edge.
    task automatic run_cycle(input logic rs, input logic fs, input logic [N_REQ-1:0] rq,
                             input logic [N_REQ-1:0] lt, input logic [N_REQ*ADDR_W-1:0] ad);
        logic [N_REQ-1:0]  exp_gnt;
        logic [N_REQ-1:0]  exp_rv;
        logic [ADDR_W-1:0] exp_addr;
        logic [ADDR_W-1:0] own_addr;
        logic              bt;
        logic              exp_busy;
        logic              done;
        @(posedge clk);
        #1;
        rstn = rs; frame_start = fs; req = rq; last = lt; addr_in = ad;
        cyc++;
        @(negedge clk);
        exp_gnt  = (m_owner >= 0) ? (N_REQ'(1) << m_owner) : '0;
        bt       = (m_owner >= 0) && rq[m_owner] && !fs && rs;
        own_addr = (m_owner >= 0) ? ad[m_owner*ADDR_W +: ADDR_W] : '0;
        exp_addr = bt ? own_addr : m_hold;
        exp_busy = (m_owner >= 0) || (q_due.size() > 0);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("rom_en", 32'(rom_en), 32'(bt));
        check("rom_addr", 32'(rom_addr), 32'(exp_addr));
        check("busy", 32'(busy), 32'(exp_busy));
        exp_rv = '0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            exp_rv = N_REQ'(1) << q_who[0];
            check("rd_data", 32'(rd_data), 32'(rom_word(q_addr[0])));
            void'(q_due.pop_front());
            void'(q_who.pop_front());
            void'(q_addr.pop_front());
        end
        check("rd_valid", 32'(rd_valid), 32'(exp_rv));

        if (!rs) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_hold = '0;
            q_due.delete(); q_who.delete(); q_addr.delete();
        end else if (m_owner < 0) begin
            if (fs) begin
                m_ptr = 0;
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (m_owner < 0 && rq[(m_ptr + k) % N_REQ]) m_owner = (m_ptr + k) % N_REQ;
                end
                m_cnt = 0;
            end
        end else begin
            done = 1'b0;
            if (bt) begin
                q_due.push_back(cyc + ROM_LAT);
                q_who.push_back(m_owner);
                q_addr.push_back(own_addr);
                m_hold = own_addr;
                m_cnt++;
                if (lt[m_owner] || m_cnt == MAX_BURST) done = 1'b1;
            end else begin
                done = 1'b1;
            end
            if (done) begin
                m_ptr   = fs ? 0 : (m_owner + 1) % N_REQ;
                m_owner = -1;
            end
        end
    endtask

    function automatic logic [N_REQ*ADDR_W-1:0] rand_addrs();
        logic [N_REQ*ADDR_W-1:0] a;
        for (int i = 0; i < N_REQ; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        return a;
    endfunction

    initial begin
        logic [N_REQ-1:0]        rq;
        logic [N_REQ-1:0]        lt;
        logic [N_REQ*ADDR_W-1:0] ad;
        logic                    fs;
        logic                    rs;

        rstn = 1'b0; frame_start = 1'b0; req = '0; last = '0; addr_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rom_en", 32'(rom_en), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single burst to requester 2: addresses 100..102, last on the third beat.
        ad = '0;
        for (int c = 0; c < 4; c++) begin
            ad[2*ADDR_W +: ADDR_W] = ADDR_W'(99 + c);
            lt = (c == 3) ? 4'b0100 : 4'b0000;
            run_cycle(1'b1, 1'b0, (c < 4) ? 4'b0100 : 4'b0000, lt, ad);
        end
        for (int c = 0; c < 4; c++) run_cycle(1'b1, 1'b0, '0, '0, ad);

        // Randomised phases: round-robin with short bursts, long bursts hitting the cap,
        // frequent drops, then mixed frame_start and reset.
        for (int mode = 0; mode < 4; mode++) begin
            rq = '0;
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if ($urandom_range(0, (mode == 2) ? 2 : 7) == 0) rq[i] = ~rq[i];
                end
                case (mode)
                    0:       lt = 4'($urandom);
                    1:       lt = ($urandom_range(0, 15) == 0) ? 4'($urandom) : '0;
                    2:       lt = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
                    default: lt = 4'($urandom);
                endcase
                if (mode == 1 && c < 100) rq = 4'b1010;
                fs = (mode == 3) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 60) == 0);
                rs = (mode == 3) ? ($urandom_range(0, 40) != 0) : 1'b1;
                ad = rand_addrs();
                run_cycle(rs, fs, rq, lt, ad);
            end
        end

        for (int c = 0; c < 12; c++) run_cycle(1'b1, 1'b0, '0, '0, rand_addrs());
        check("drain_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
